// File: rtl/mem_stage_if.sv
// SRAM-like data port between the MEM stage (master) and data memory (slave).
// Requests complete in two phases: addr_ok accepts the request, data_ok returns data or a write ack.
interface mem_stage_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on the data SRAM port, aligns load data,
// and forwards results to ID and WB.
module mem_stage #(
  parameter int unsigned EX_TO_MEM_BUS_WD = 109,
  parameter int unsigned MEM_TO_WB_BUS_WD = 104,
  parameter int unsigned MEM_FWD_BUS_WD   = 39
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_bus,
  input  logic                        EX_to_MEM_valid,
  output logic                        MEM_allow_in,
  output logic [MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_bus,
  output logic                        MEM_to_WB_valid,
  input  logic                        WB_allow_in,
  output logic [MEM_FWD_BUS_WD-1:0]   MEM_fwd_bus,
  mem_stage_if.master                 data_sram
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitData, StDone} state_e;

  state_e                      state_q, state_d;
  logic                        mem_valid_q;
  logic [EX_TO_MEM_BUS_WD-1:0] bus_q;
  logic [31:0]                 load_data_q, load_data_d;

  logic [2:0]  ld_st_type;
  logic        mem_en, mem_we, sel_rf_w_en;
  logic [31:0] store_data, pc_plus_4, alu_res;
  logic [1:0]  sel_rf_w_data;
  logic [4:0]  w_addr;

  assign ld_st_type    = bus_q[108:106];
  assign mem_en        = bus_q[105];
  assign mem_we        = bus_q[104];
  assign store_data    = bus_q[103:72];
  assign sel_rf_w_data = bus_q[71:70];
  assign sel_rf_w_en   = bus_q[69];
  assign pc_plus_4     = bus_q[68:37];
  assign alu_res       = bus_q[36:5];
  assign w_addr        = bus_q[4:0];

  logic mem_ready_go, accept, handoff;

  assign mem_ready_go    = ~mem_en | (state_q == StDone);
  assign MEM_allow_in    = ~mem_valid_q | (mem_ready_go & WB_allow_in);
  assign MEM_to_WB_valid = mem_valid_q & mem_ready_go;
  assign accept          = EX_to_MEM_valid & MEM_allow_in;
  assign handoff         = MEM_to_WB_valid & WB_allow_in;

  // Request fields derive only from the latched bus, so they stay stable while req is high.
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] wdata;

  always_comb begin
    case (ld_st_type)
      3'b001, 3'b010: size = 2'd0;
      3'b011, 3'b100: size = 2'd1;
      default:        size = 2'd2;
    endcase
  end

  always_comb begin
    wstrb = 4'b0000;
    wdata = store_data;
    case (size)
      2'd0: begin
        wdata = {4{store_data[7:0]}};
        if (mem_we) wstrb = 4'b0001 << alu_res[1:0];
      end
      2'd1: begin
        wdata = {2{store_data[15:0]}};
        if (mem_we) wstrb = alu_res[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        if (mem_we) wstrb = 4'b1111;
      end
    endcase
  end

  assign data_sram.data_sram_req   = (state_q == StReq);
  assign data_sram.data_sram_wr    = mem_we;
  assign data_sram.data_sram_size  = size;
  assign data_sram.data_sram_wstrb = wstrb;
  assign data_sram.data_sram_addr  = alu_res;
  assign data_sram.data_sram_wdata = wdata;

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_aligned;

  always_comb begin
    case (alu_res[1:0])
      2'd0:    rd_byte = data_sram.data_sram_rdata[7:0];
      2'd1:    rd_byte = data_sram.data_sram_rdata[15:8];
      2'd2:    rd_byte = data_sram.data_sram_rdata[23:16];
      default: rd_byte = data_sram.data_sram_rdata[31:24];
    endcase
    rd_half = alu_res[1] ? data_sram.data_sram_rdata[31:16] : data_sram.data_sram_rdata[15:0];
    case (ld_st_type)
      3'b001:  load_aligned = {{24{rd_byte[7]}}, rd_byte};
      3'b010:  load_aligned = {24'b0, rd_byte};
      3'b011:  load_aligned = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_aligned = {16'b0, rd_half};
      default: load_aligned = data_sram.data_sram_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    load_data_d = load_data_q;
    if (accept) begin
      state_d     = EX_to_MEM_bus[105] ? StReq : StIdle;
      load_data_d = 32'b0;
    end else begin
      case (state_q)
        StReq: begin
          if (data_sram.data_sram_addr_ok) state_d = StWaitData;
        end
        StWaitData: begin
          // Store acks complete the op too, but leave load_data at zero.
          if (data_sram.data_sram_data_ok) begin
            state_d     = StDone;
            load_data_d = mem_we ? 32'b0 : load_aligned;
          end
        end
        StDone: begin
          if (handoff) state_d = StIdle;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      mem_valid_q <= 1'b0;
      bus_q       <= '0;
      load_data_q <= 32'b0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
      if (MEM_allow_in) mem_valid_q <= EX_to_MEM_valid;
      if (accept)       bus_q       <= EX_to_MEM_bus;
    end
  end

  logic [31:0] fwd_value;

  always_comb begin
    case (sel_rf_w_data)
      2'b10:   fwd_value = load_data_q;
      2'b01:   fwd_value = pc_plus_4 + 32'd4;
      2'b11:   fwd_value = 32'b0;
      default: fwd_value = alu_res;
    endcase
  end

  assign MEM_fwd_bus = {mem_valid_q & sel_rf_w_en,
                        mem_valid_q & (sel_rf_w_data == 2'b10) & (state_q != StDone),
                        w_addr, fwd_value};

  assign MEM_to_WB_bus = {sel_rf_w_data, sel_rf_w_en, pc_plus_4, alu_res, load_data_q, w_addr};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios then random traffic, all checked cycle by cycle
// against a transaction-level model of the stage.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic [108:0] EX_to_MEM_bus;
  logic         EX_to_MEM_valid;
  logic         MEM_allow_in;
  logic [103:0] MEM_to_WB_bus;
  logic         MEM_to_WB_valid;
  logic         WB_allow_in;
  logic [38:0]  MEM_fwd_bus;

  mem_stage_if sram ();

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .EX_to_MEM_bus   (EX_to_MEM_bus),
    .EX_to_MEM_valid (EX_to_MEM_valid),
    .MEM_allow_in    (MEM_allow_in),
    .MEM_to_WB_bus   (MEM_to_WB_bus),
    .MEM_to_WB_valid (MEM_to_WB_valid),
    .WB_allow_in     (WB_allow_in),
    .MEM_fwd_bus     (MEM_fwd_bus),
    .data_sram       (sram)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_req_cycles = 0;
  int dut_handoffs   = 0;

  // Model: the op held by the stage and the progress of its memory transaction.
  logic         m_known = 1'b0;
  logic         m_has, m_addr_acc, m_done;
  logic [108:0] m_op;
  logic [31:0]  m_ld;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [108:0] mk_op(input logic [2:0] t, input logic en, input logic we,
                                         input logic [31:0] sd, input logic [1:0] sel,
                                         input logic wen, input logic [31:0] pc4,
                                         input logic [31:0] alu, input logic [4:0] wa);
    return {t, en, we, sd, sel, wen, pc4, alu, wa};
  endfunction

  function automatic int access_bytes(input logic [2:0] t);
    if (t == 3'd1 || t == 3'd2) return 1;
    if (t == 3'd3 || t == 3'd4) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] rd);
    longint b, h;
    b = longint'((rd >> (8 * (a % 4))) % 256);
    h = longint'((rd >> (16 * ((a / 2) % 2))) % 65536);
    case (t)
      3'd1:    return 32'(b >= 128 ? b - 256 : b);
      3'd2:    return 32'(b);
      3'd3:    return 32'(h >= 32768 ? h - 65536 : h);
      3'd4:    return 32'(h);
      default: return rd;
    endcase
  endfunction

  // {wr, size, wstrb, addr, wdata} the request should carry for op o.
  function automatic logic [70:0] exp_req_fields(input logic [108:0] o);
    int          n;
    logic [31:0] a, sd, wd;
    logic [3:0]  strb;
    logic [1:0]  sz;
    n  = access_bytes(o[108:106]);
    a  = o[36:5];
    sd = o[103:72];
    if (n == 1) begin
      sz = 2'd0; wd = (sd % 256) * 32'h01010101; strb = 4'(1 << (a % 4));
    end else if (n == 2) begin
      sz = 2'd1; wd = (sd % 65536) * 32'h00010001; strb = 4'(3 << (a % 4 / 2 * 2));
    end else begin
      sz = 2'd2; wd = sd; strb = 4'hF;
    end
    if (!o[104]) strb = 4'h0;
    return {o[104], sz, strb, a, wd};
  endfunction

  task automatic cycle(input logic rst_n, input logic v, input logic [108:0] op,
                       input logic wba, input logic aok, input logic dok,
                       input logic [31:0] rd, output logic acc);
    logic        e_mem, e_req, e_ready, e_allow, waiting;
    logic [31:0] fval;
    resetn                      = rst_n;
    EX_to_MEM_valid             = v;
    EX_to_MEM_bus               = op;
    WB_allow_in                 = wba;
    sram.data_sram_addr_ok      = aok;
    sram.data_sram_data_ok      = dok;
    sram.data_sram_rdata        = rd;
    #1;
    e_mem   = m_has && m_op[105];
    e_req   = e_mem && !m_addr_acc;
    e_ready = m_has && (!m_op[105] || m_done);
    e_allow = !m_has || (e_ready && wba);
    acc     = rst_n && v && e_allow;
    if (m_known) begin
      chk("req", sram.data_sram_req, e_req);
      chk("allow_in", MEM_allow_in, e_allow);
      chk("wb_valid", MEM_to_WB_valid, e_ready);
      if (e_ready)
        chk("wb_bus", MEM_to_WB_bus,
            {m_op[71:70], m_op[69], m_op[68:37], m_op[36:5], m_ld, m_op[4:0]});
      if (e_req)
        chk("req_fields", {sram.data_sram_wr, sram.data_sram_size, sram.data_sram_wstrb,
                           sram.data_sram_addr, sram.data_sram_wdata}, exp_req_fields(m_op));
      if (m_has) begin
        case (m_op[71:70])
          2'b10:   fval = m_ld;
          2'b01:   fval = m_op[68:37] + 32'd4;
          2'b11:   fval = 32'd0;
          default: fval = m_op[36:5];
        endcase
        chk("fwd_bus", MEM_fwd_bus,
            {m_op[69], m_op[71:70] == 2'b10 && !m_done, m_op[4:0], fval});
      end else begin
        chk("fwd_idle", MEM_fwd_bus[38:37], 2'b00);
      end
    end
    if (sram.data_sram_req) dut_req_cycles++;
    if (MEM_to_WB_valid && wba) dut_handoffs++;
    if (!rst_n) begin
      m_known = 1'b1; m_has = 1'b0; m_addr_acc = 1'b0; m_done = 1'b0; m_ld = 32'd0;
    end else begin
      waiting = e_mem && m_addr_acc && !m_done;
      if (e_req && aok) begin
        m_addr_acc = 1'b1;
      end else if (waiting && dok) begin
        m_done = 1'b1;
        m_ld   = m_op[104] ? 32'd0 : exp_load(m_op[108:106], m_op[36:5], rd);
      end
      if (e_ready && wba) m_has = 1'b0;
      if (acc) begin
        m_has = 1'b1; m_op = op; m_addr_acc = 1'b0; m_done = 1'b0; m_ld = 32'd0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [108:0] op_alu, op_lb, op_lbu, op_sh, op_lw, op_alu2, snap, p_op;
    logic         acc, p_valid, we;
    logic [2:0]   t;

    m_has = 1'b0; m_addr_acc = 1'b0; m_done = 1'b0; m_ld = 32'd0; m_op = '0;
    resetn = 1'b0; EX_to_MEM_valid = 1'b0; EX_to_MEM_bus = '0; WB_allow_in = 1'b0;
    sram.data_sram_addr_ok = 1'b0; sram.data_sram_data_ok = 1'b0; sram.data_sram_rdata = '0;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 32'd0, acc);
    chk("reset_req", sram.data_sram_req, 1'b0);
    chk("reset_wb_valid", MEM_to_WB_valid, 1'b0);
    chk("reset_allow_in", MEM_allow_in, 1'b1);

    // Plain ALU op: valid to WB the very next cycle, no memory request.
    op_alu = mk_op(3'd0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b1, 32'h100, 32'h00001234, 5'd5);
    cycle(1'b1, 1'b1, op_alu, 1'b1, 1'b0, 1'b0, 32'd0, acc);
    chk("alu_wb_valid", MEM_to_WB_valid, 1'b1);
    chk("alu_res_field", MEM_to_WB_bus[68:37], 32'h00001234);
    chk("alu_load_field", MEM_to_WB_bus[36:5], 32'h0);
    chk("alu_no_req", sram.data_sram_req, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 32'd0, acc);

    // LB and LBU of the same word.
    op_lb  = mk_op(3'd1, 1'b1, 1'b0, 32'd0, 2'b10, 1'b1, 32'h200, 32'h00001003, 5'd6);
    op_lbu = mk_op(3'd2, 1'b1, 1'b0, 32'd0, 2'b10, 1'b1, 32'h204, 32'h00001003, 5'd7);
    cycle(1'b1, 1'b1, op_lb, 1'b1, 1'b0, 1'b0, 32'd0, acc);
    chk("lb_size", sram.data_sram_size, 2'd0);
    chk("lb_wstrb", sram.data_sram_wstrb, 4'b0000);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 32'd0, acc);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h80FF1234, acc);
    chk("lb_data", MEM_to_WB_bus[36:5], 32'hFFFFFF80);
    chk("lb_fwd", MEM_fwd_bus[31:0], 32'hFFFFFF80);
    cycle(1'b1, 1'b1, op_lbu, 1'b1, 1'b0, 1'b0, 32'd0, acc);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 32'd0, acc);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h80FF1234, acc);
    chk("lbu_data", MEM_to_WB_bus[36:5], 32'h00000080);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 32'd0, acc);

    // SH to the upper half-word.
    op_sh = mk_op(3'd3, 1'b1, 1'b1, 32'h0000BEEF, 2'b00, 1'b0, 32'h300, 32'h00002002, 5'd0);
    cycle(1'b1, 1'b1, op_sh, 1'b1, 1'b0, 1'b0, 32'd0, acc);
    chk("sh_wr", sram.data_sram_wr, 1'b1);
    chk("sh_size", sram.data_sram_size, 2'd1);
    chk("sh_wstrb", sram.data_sram_wstrb, 4'b1100);
    chk("sh_wdata", sram.data_sram_wdata, 32'hBEEFBEEF);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 32'd0, acc);
    chk("sh_wait_no_valid", MEM_to_WB_valid, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'd0, acc);
    chk("sh_done_valid", MEM_to_WB_valid, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 32'd0, acc);

    // LW with slow addr_ok, then WB backpressure.
    op_lw = mk_op(3'd0, 1'b1, 1'b0, 32'd0, 2'b10, 1'b1, 32'h400, 32'h00003000, 5'd7);
    cycle(1'b1, 1'b1, op_lw, 1'b1, 1'b0, 1'b0, 32'd0, acc);
    dut_req_cycles = 0;
    chk("lw_load_not_ready", MEM_fwd_bus[37], 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 32'd0, acc);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 32'd0, acc);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D, acc);
    chk("lw_req_cycles", dut_req_cycles, 4);
    chk("lw_ready", MEM_fwd_bus[37], 1'b0);
    snap = {5'd0, MEM_to_WB_bus};
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, op_alu, 1'b0, 1'b0, 1'b0, 32'd0, acc);
      chk("bp_bus_stable", {5'd0, MEM_to_WB_bus}, snap);
    end
    cycle(1'b1, 1'b1, op_alu, 1'b1, 1'b0, 1'b0, 32'd0, acc);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 32'd0, acc);

    // Reset while waiting for data, then a stray data_ok.
    cycle(1'b1, 1'b1, op_lw, 1'b1, 1'b0, 1'b0, 32'd0, acc);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 32'd0, acc);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 32'd0, acc);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h12345678, acc);
    chk("rst_wb_valid", MEM_to_WB_valid, 1'b0);
    chk("rst_req", sram.data_sram_req, 1'b0);
    chk("rst_fwd_en", MEM_fwd_bus[38], 1'b0);

    // Back-to-back ALU, LW, ALU.
    op_alu2 = mk_op(3'd0, 1'b0, 1'b0, 32'd0, 2'b01, 1'b1, 32'h500, 32'h0000ABCD, 5'd9);
    dut_handoffs = 0;
    cycle(1'b1, 1'b1, op_alu, 1'b1, 1'b0, 1'b0, 32'd0, acc);
    cycle(1'b1, 1'b1, op_lw, 1'b1, 1'b1, 1'b0, 32'd0, acc);
    cycle(1'b1, 1'b1, op_alu2, 1'b1, 1'b1, 1'b0, 32'd0, acc);
    chk("b2b_alu2_stalled", acc, 1'b0);
    cycle(1'b1, 1'b1, op_alu2, 1'b1, 1'b0, 1'b1, 32'h0BADF00D, acc);
    cycle(1'b1, 1'b1, op_alu2, 1'b1, 1'b0, 1'b0, 32'd0, acc);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 32'd0, acc);
    chk("b2b_handoffs", dut_handoffs, 3);

    // Random traffic; upstream holds an offered op until it is accepted.
    p_valid = 1'b0;
    p_op    = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!p_valid && ($urandom % 100) < 60) begin
        we = 1'($urandom);
        case ($urandom % 3)
          0:       t = 3'd0;
          1:       t = 3'd1;
          default: t = 3'd3;
        endcase
        if (!we) t = 3'($urandom % 5);
        p_op = mk_op(t, 1'($urandom), we, $urandom, 2'($urandom), 1'($urandom),
                     $urandom, $urandom, 5'($urandom));
        p_valid = 1'b1;
      end
      cycle(($urandom % 200) != 0, p_valid, p_op, ($urandom % 4) != 0,
            1'($urandom), 1'($urandom), $urandom, acc);
      if (acc || !resetn) p_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between EX and WB of the five-stage in-order CPU.
- Takes the EX result bundle and issues load/store requests on a req/addr_ok/data_ok SRAM-like data port.
- Aligns and sign/zero-extends load data, then hands WB a 104-bit MEM_to_WB_bus.
- Drives a forwarding bus to ID for bypass and load-use stall detection.

Parameters:
EX_TO_MEM_BUS_WD, 109, width of the incoming EX bundle
MEM_TO_WB_BUS_WD, 104, width of the outgoing WB bundle
MEM_FWD_BUS_WD, 39, width of the forwarding bus to ID

Ports:
clk  in  1  single clock; all state updates on posedge
resetn  in  1  synchronous, active-low reset
EX_to_MEM_bus  in  109  [108:106] ld_st_type (000 W, 001 B, 010 BU, 011 H, 100 HU); [105] mem_en; [104] mem_we; [103:72] store_data; [71:70] sel_rf_w_data; [69] sel_rf_w_en; [68:37] PC_plus_4; [36:5] alu_res/address; [4:0] w_addr
EX_to_MEM_valid  in  1  upstream valid
MEM_allow_in  out  1  stage can accept
MEM_to_WB_bus  out  104  {sel_rf_w_data[1:0], sel_rf_w_en, PC_plus_4, alu_res, load_data, w_addr}
MEM_to_WB_valid  out  1  downstream valid
WB_allow_in  in  1  downstream ready
MEM_fwd_bus  out  39  {fwd_w_en, load_not_ready, w_addr[4:0], fwd_value[31:0]}
data_sram_req  out  1  request valid
data_sram_wr  out  1  1 = store
data_sram_size  out  2  0 byte, 1 half, 2 word
data_sram_wstrb  out  4  byte enables
data_sram_addr  out  32  access address
data_sram_wdata  out  32  store data
data_sram_addr_ok  in  1  request accepted
data_sram_data_ok  in  1  read data / write ack valid
data_sram_rdata  in  32  read data

Behaviour:
- Reset (resetn=0 at posedge):
  - MEM_valid=0; FSM=IDLE; load-data register cleared.
  - Outputs: data_sram_req=0, MEM_to_WB_valid=0, MEM_allow_in=1.
- Handshake:
  - MEM_allow_in = ~MEM_valid | (MEM_ready_go & WB_allow_in).
  - On EX_to_MEM_valid & MEM_allow_in: latch the bus; MEM_valid<=1.
  - If MEM_allow_in and no upstream valid: MEM_valid<=0.
  - MEM_to_WB_valid = MEM_valid & MEM_ready_go.
  - MEM_ready_go = ~mem_en | (FSM==DONE).
- FSM (IDLE, REQ, WAIT_DATA, DONE):
  - Accepting an op with mem_en=1: FSM<=REQ. Otherwise FSM<=IDLE.
  - REQ: data_sram_req=1. On addr_ok go to WAIT_DATA.
  - WAIT_DATA: on data_ok, capture the aligned load value and go to DONE. data_ok is honoured only in WAIT_DATA, so at earliest the cycle after addr_ok.
  - DONE: hold until the op leaves, i.e. a handoff to WB. Then FSM goes to REQ if the newly accepted op has mem_en, else IDLE.
  - Stores complete on data_ok (write ack) exactly like loads.
- Latency:
  - Non-memory op accepted at edge N: MEM_to_WB_valid=1 in cycle N+1.
  - Memory op with immediate addr_ok and data_ok one cycle later: valid to WB in cycle N+3.
- Request fields (stable while req=1):
  - data_sram_addr = alu_res.
  - data_sram_wr = mem_we.
  - size: W=2, H/HU=1, B/BU=0.
  - wstrb: loads 0000; SW 1111; SH 0011<<{addr[1],1'b0}; SB 0001<<addr[1:0].
  - wdata: SW = store_data; SH = {2{store_data[15:0]}}; SB = {4{store_data[7:0]}}.
- Load alignment:
  - B/BU: byte = rdata>>(8*addr[1:0]).
  - H/HU: half = rdata>>(16*addr[1]). addr[0] is ignored; no misalignment exceptions.
  - B and H sign-extend; BU and HU zero-extend.
  - load_data field is 0 for non-loads.
- Forwarding bus:
  - fwd_w_en = MEM_valid & sel_rf_w_en.
  - load_not_ready = MEM_valid & sel_rf_w_data==10 & FSM!=DONE.
  - fwd_value = load_data if sel==10; PC_plus_4+4 if sel==01; 0 if sel==11; else alu_res.
- Backpressure: with WB_allow_in=0 in DONE, the bus, load_data and FSM hold; no new request is issued.
- Reset mid-operation: pending REQ or WAIT_DATA is abandoned. Any data_ok arriving after reset with FSM≠WAIT_DATA is ignored.
- Simultaneous events: handoff to WB and acceptance of a new op in the same edge is legal and supports full throughput for non-memory ops.

Test Plan:
- ALU op (alu_res=0x00001234, sel=00, w_addr=5), WB_allow_in=1 -> MEM_to_WB_valid next cycle; bus alu_res=0x1234, load_data=0; no data_sram_req.
- LB addr=0x1003, rdata=0x80FF1234 -> size=0, wstrb=0000; load_data=0xFFFFFF80. LBU on the same data -> 0x00000080.
- SH addr=0x2002, store_data=0x0000BEEF -> req with wr=1, size=1, wstrb=1100, wdata=0xBEEFBEEF; valid to WB only after data_ok.
- LW with addr_ok delayed 3 cycles and WB_allow_in=0 for 2 cycles after DONE:
  - req held for 4 cycles; load_not_ready=1 until DONE.
  - Bus stable under backpressure; MEM_allow_in=0 throughout.
- resetn=0 during WAIT_DATA, then a stray data_ok -> MEM_valid=0, req=0, MEM_to_WB_valid=0; stray data_ok has no effect.
- Back-to-back: ALU, LW, ALU with immediate addr_ok/data_ok -> WB sees three valid ops in order; second ALU stalls while LW is in flight.
